sha256_msg_sched: RTL and testbench

SHA256_MSG_SCHED -- requirements
Module: sha256_msg_sched

---
 rtl/sha256_msg_sched.sv | 132 +++++++++++++
 tb/tb_sha256_msg_sched.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/sha256_msg_sched.sv
// sha256_msg_sched
//   SHA-256 message schedule generator. Captures one padded 512-bit block
//   into a 16-word circular buffer and streams W0..W63 to a hash core over
//   a valid/ready handshake. Words 16..63 are formed combinationally from
//   the buffer and written back over the oldest entry when consumed.
//
// Parameters
//   BIG_ENDIAN   1: W0 = blk_data_i[511:480]; 0: W0 = blk_data_i[31:0]
// Configuration macro
//   SHA256_KT_ROM_EN  defined: kt_o comes from an internal 64-entry Kt table
//                     undefined: kt_o = 0, the core reads Kt via round_o
// Ports
//   clk, rst       clock (rising edge), async active-high reset
//   blk_valid_i    padded block available
//   blk_data_i     512-bit block (16 x 32-bit words)
//   blk_ready_o    block can be captured (IDLE)
//   wt_valid_o     wt_o/kt_o/round_o valid (RUN)
//   wt_ready_i     hash core consumes the current round
//   wt_o, kt_o     schedule word Wt, round constant Kt
//   round_o        round index t
//   done_o         one-cycle pulse after round 63 is consumed
module sha256_msg_sched #(
  parameter bit BIG_ENDIAN = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         blk_valid_i,
  input  logic [511:0] blk_data_i,
  output logic         blk_ready_o,
  output logic         wt_valid_o,
  input  logic         wt_ready_i,
  output logic [31:0]  wt_o,
  output logic [31:0]  kt_o,
  output logic [5:0]   round_o,
  output logic         done_o
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  logic [0:0]        state_q, state_d;
  logic [5:0]        t_q, t_d;
  logic [15:0][31:0] buf_q, buf_d;
  logic              done_q, done_d;
  logic [31:0]       w_new, w_cur;
  logic [3:0]        ti;

  function automatic logic [31:0] sig0(input logic [31:0] x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
  endfunction

  function automatic logic [31:0] sig1(input logic [31:0] x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
  endfunction

  // 4-bit index arithmetic wraps mod 16, which is exactly the circular
  // buffer addressing: t-15 == t+1 and t-16 == t (the slot being replaced).
  assign ti    = t_q[3:0];
  assign w_new = sig1(buf_q[ti - 4'd2]) + buf_q[ti - 4'd7]
               + sig0(buf_q[ti + 4'd1]) + buf_q[ti];
  assign w_cur = (t_q[5:4] == 2'b00) ? buf_q[ti] : w_new;

  always_comb begin
    state_d = state_q;
    t_d     = t_q;
    buf_d   = buf_q;
    done_d  = 1'b0;
    if (state_q == IDLE) begin
      if (blk_valid_i) begin
        for (int i = 0; i < 16; i++)
          buf_d[i] = BIG_ENDIAN ? blk_data_i[511-32*i -: 32] : blk_data_i[32*i +: 32];
        t_d     = 6'd0;
        state_d = RUN;
      end
    end else if (wt_ready_i) begin
      if (t_q[5:4] != 2'b00) buf_d[ti] = w_new;
      if (t_q == 6'd63) begin
        t_d     = 6'd0;
        state_d = IDLE;
        done_d  = 1'b1;
      end else begin
        t_d = t_q + 6'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      t_q     <= '0;
      buf_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      t_q     <= t_d;
      buf_q   <= buf_d;
      done_q  <= done_d;
    end
  end

  assign blk_ready_o = (state_q == IDLE);
  assign wt_valid_o  = (state_q == RUN);
  // Gate wt_o so it reads 0 whenever no round is being presented.
  assign wt_o        = wt_valid_o ? w_cur : 32'd0;
  assign round_o     = t_q;
  assign done_o      = done_q;

`ifdef SHA256_KT_ROM_EN
  localparam logic [31:0] K_ROM [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };
  assign kt_o = K_ROM[t_q];
`else
  assign kt_o = 32'd0;
`endif

endmodule

// File: tb/tb_sha256_msg_sched.sv
module tb_sha256_msg_sched;
  logic         clk = 1'b0;
  logic         rst;
  logic         blk_valid_i;
  logic [511:0] blk_data_i;
  logic         blk_ready_o, wt_valid_o, wt_ready_i, done_o;
  logic [31:0]  wt_o, kt_o;
  logic [5:0]   round_o;

  int n_chk = 0;
  int n_fail = 0;
  logic [31:0] w_exp [64];

  sha256_msg_sched dut (
    .clk(clk), .rst(rst), .blk_valid_i(blk_valid_i), .blk_data_i(blk_data_i),
    .blk_ready_o(blk_ready_o), .wt_valid_o(wt_valid_o), .wt_ready_i(wt_ready_i),
    .wt_o(wt_o), .kt_o(kt_o), .round_o(round_o), .done_o(done_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  // FIPS 180-4 schedule, straight from the definition (big-endian words).
  task automatic model(input logic [511:0] blk);
    for (int i = 0; i < 64; i++) begin
      if (i < 16) w_exp[i] = blk[511-32*i -: 32];
      else w_exp[i] = (rotr(w_exp[i-2], 17) ^ rotr(w_exp[i-2], 19) ^ (w_exp[i-2] >> 10))
                    + w_exp[i-7]
                    + (rotr(w_exp[i-15], 7) ^ rotr(w_exp[i-15], 18) ^ (w_exp[i-15] >> 3))
                    + w_exp[i-16];
    end
  endtask

  function automatic logic [511:0] rand_blk();
    logic [511:0] b;
    for (int i = 0; i < 16; i++) b[32*i +: 32] = $urandom;
    return b;
  endfunction

  task automatic chk_kt(input int t);
`ifdef SHA256_KT_ROM_EN
    if (t == 0)  chk("kt0", kt_o, 32'h428a2f98);
    if (t == 63) chk("kt63", kt_o, 32'hc67178f2);
`else
    chk("kt_zero", kt_o, 32'd0);
`endif
  endtask

  task automatic chk_idle_reset();
    chk("rst_valid", {31'd0, wt_valid_o}, 32'd0);
    chk("rst_ready", {31'd0, blk_ready_o}, 32'd1);
    chk("rst_wt", wt_o, 32'd0);
    chk("rst_round", {26'd0, round_o}, 32'd0);
    chk("rst_done", {31'd0, done_o}, 32'd0);
`ifdef SHA256_KT_ROM_EN
    chk("rst_kt", kt_o, 32'h428a2f98);
`else
    chk("rst_kt", kt_o, 32'd0);
`endif
  endtask

  task automatic capture(input logic [511:0] blk);
    chk("cap_ready", {31'd0, blk_ready_o}, 32'd1);
    blk_valid_i = 1'b1;
    blk_data_i  = blk;
    model(blk);
    step();
    blk_valid_i = 1'b0;
  endtask

  // Streams rounds starting at t=0. stall_at/abort_at < 0 disable the feature.
  // nxt_valid/nxt_data are driven in the final round so the done cycle sees them.
  task automatic stream(input int stall_at, input int stall_len, input bit toggle,
                        input int abort_at, input bit nxt_valid, input logic [511:0] nxt_data);
    wt_ready_i = 1'b1;
    for (int t = 0; t < 64; t++) begin
      if (t == abort_at) begin
        rst = 1'b1; #1;
        chk_idle_reset();
        for (int k = 0; k < 3; k++) begin
          step();
          chk("abort_done", {31'd0, done_o}, 32'd0);
        end
        rst = 1'b0;
        return;
      end
      chk("run_valid", {31'd0, wt_valid_o}, 32'd1);
      chk("run_ready", {31'd0, blk_ready_o}, 32'd0);
      chk("run_done", {31'd0, done_o}, 32'd0);
      chk("round", {26'd0, round_o}, t);
      chk("wt", wt_o, w_exp[t]);
      chk_kt(t);
      if (t == stall_at) begin
        logic [31:0] hw, hk; logic [5:0] hr;
        hw = wt_o; hk = kt_o; hr = round_o;
        wt_ready_i = 1'b0;
        for (int k = 0; k < stall_len; k++) begin
          step();
          chk("stall_wt", wt_o, w_exp[t]);
          chk("stall_wt_hold", wt_o, hw);
          chk("stall_kt", kt_o, hk);
          chk("stall_round", {26'd0, round_o}, {26'd0, hr});
        end
        wt_ready_i = 1'b1;
      end
      if (toggle) begin
        blk_valid_i = 1'($urandom);
        blk_data_i  = rand_blk();
      end
      if (t == 63) begin
        blk_valid_i = nxt_valid;
        blk_data_i  = nxt_data;
      end
      step();
    end
    chk("done_pulse", {31'd0, done_o}, 32'd1);
    chk("done_ready", {31'd0, blk_ready_o}, 32'd1);
    chk("done_valid", {31'd0, wt_valid_o}, 32'd0);
  endtask

  initial begin
    logic [511:0] abc, b1, b2;
    rst = 1'b1; blk_valid_i = 1'b0; blk_data_i = '0; wt_ready_i = 1'b1;
    #12;
    chk_idle_reset();
    step(); rst = 1'b0; step();
    chk_idle_reset();

    // Scenario 1: "abc" block with fixed expected words
    abc = {32'h61626380, 448'd0, 32'h00000018};
    capture(abc);
    chk("abc_w16", w_exp[16], 32'h61626380);
    chk("abc_w17", w_exp[17], 32'h000F0000);
    chk("abc_t0", wt_o, 32'h61626380);
    stream(-1, 0, 1'b0, -1, 1'b0, '0);
    step();
    chk("done_once", {31'd0, done_o}, 32'd0);

    // Scenario 2: 5-cycle stall at t=20
    capture(abc);
    stream(20, 5, 1'b0, -1, 1'b0, '0);
    step();

    // Scenario 3: back-to-back blocks, valid held high
    b1 = rand_blk(); b2 = rand_blk();
    capture(b1);
    blk_valid_i = 1'b1; blk_data_i = b2;
    stream(-1, 0, 1'b0, -1, 1'b1, b2);
    model(b2);
    step();
    blk_valid_i = 1'b0;
    stream(-1, 0, 1'b0, -1, 1'b0, '0);
    step();

    // Scenario 4: reset at t=40, then new block right after release
    capture(rand_blk());
    stream(-1, 0, 1'b0, 40, 1'b0, '0);
    chk_idle_reset();
    capture(rand_blk());
    stream(7, 2, 1'b0, -1, 1'b0, '0);
    step();

    // Scenario 5: blk_valid_i toggling with junk data during RUN
    capture(rand_blk());
    stream(-1, 0, 1'b1, -1, 1'b0, '0);
    blk_valid_i = 1'b0;
    step();
    chk("idle_after", {31'd0, blk_ready_o}, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
